// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the ADC3424 bring-up sequencer: FSM states, error
// codes and SPI frame layout.
package adc_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RESET  = 4'd1,
        S_POST   = 4'd2,
        S_WR_REQ = 4'd3,
        S_WR_ACK = 4'd4,
        S_GAP    = 4'd5,
        S_RD_REQ = 4'd6,
        S_RD_ACK = 4'd7,
        S_DONE   = 4'd8,
        S_TOGGLE = 4'd9,
        S_FAIL   = 4'd10
    } state_t;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_ACK_STUCK   = 2'd1;
    localparam logic [1:0] ERR_ACK_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_MISMATCH    = 2'd3;

    localparam logic       FRAME_RD    = 1'b1;
    localparam logic       FRAME_WR    = 1'b0;
    localparam logic       FRAME_W_BIT = 1'b1;
    localparam logic [5:0] FRAME_PAD   = 6'b0;

    // ADC3424 power-down control register, normally the first table entry.
    localparam logic [7:0] PDN_ADDR = 8'h15;

    function automatic logic [23:0] build_frame(input logic       is_read,
                                                input logic [7:0] addr,
                                                input logic [7:0] data);
        if (is_read)
            return {FRAME_RD, FRAME_W_BIT, FRAME_PAD, addr, 8'h00};
        return {FRAME_WR, FRAME_W_BIT, FRAME_PAD, addr, data};
    endfunction

endpackage

// File: rtl/adc_cfg_spi_txn.sv
// One SPI write or read transaction: request/ack handshake, ACK timeout
// counter and readback capture. The phase inputs come from the sequencer FSM.
module adc_cfg_spi_txn
    import adc_cfg_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_phase,
    input  logic        ack_phase,
    input  logic        is_read,
    input  logic        restart,
    input  logic [7:0]  addr,
    input  logic [7:0]  data,
    input  logic        spi_ack,
    input  logic [7:0]  adc_spi_rd_data,
    output logic        spi_req,
    output logic [23:0] spi_wr_data,
    output logic        acked,
    output logic        released,
    output logic        timeout,
    output logic [7:0]  rd_byte
);

    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  rd_byte_q, rd_byte_d;
    logic        active;

    assign active = req_phase || ack_phase;

    always_comb begin
        // NOTE: every variable is given a default first so no path can infer a latch.
        cnt_d     = '0;
        rd_byte_d = rd_byte_q;
        if (active && !restart)
            cnt_d = cnt_q + 32'd1;
        if (req_phase && is_read && spi_ack)
            rd_byte_d = adc_spi_rd_data;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            cnt_q     <= '0;
            rd_byte_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rd_byte_q <= rd_byte_d;
        end
    end

    assign spi_req     = req_phase;
    assign spi_wr_data = active ? build_frame(is_read, addr, data) : 24'h0;
    assign acked       = req_phase && spi_ack;
    assign released    = ack_phase && !spi_ack;
    assign timeout     = active && (cnt_q == 32'(ACK_TIMEOUT - 1));
    assign rd_byte     = rd_byte_q;

endmodule

// File: rtl/adc_cfg_seq.sv
// Multi-chip ADC3424 bring-up sequencer: pulses adc_reset, then writes and
// reads back every cfg_table entry on each chip with retries and timeouts.
module adc_cfg_seq
    import adc_cfg_pkg::*;
#(
    parameter int N_ADC         = 4,
    parameter int N_REGS        = 2,
    parameter int WAIT_PERIOD   = 10,
    parameter int RESET_PERIOD  = 10,
    parameter int ACK_TIMEOUT   = 1000,
    parameter int MAX_RETRY     = 2,
    parameter int TOGGLE_EN     = 1,
    parameter int TOGGLE_PERIOD = 1000,
    localparam int SEL_W        = (N_ADC > 1) ? $clog2(N_ADC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [16*N_REGS-1:0] cfg_table,
    output logic                spi_req,
    output logic [23:0]         adc_spi_wr_data,
    output logic [SEL_W-1:0]    adc_sel,
    input  logic                spi_ack,
    input  logic [7:0]          adc_spi_rd_data,
    output logic                adc_reset,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [SEL_W-1:0]    err_adc,
    output logic [3:0]          err_reg,
    output logic [3:0]          state,
    output logic                toggle
);

    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]   adc_q, adc_d;
    logic [3:0]         reg_q, reg_d;
    logic [2:0]         retry_q, retry_d;
    logic               next_rd_q, next_rd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               toggle_q, toggle_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [SEL_W-1:0]   err_adc_q, err_adc_d;
    logic [3:0]         err_reg_q, err_reg_d;

    logic [15:0]        entry;
    logic               txn_acked, txn_released, txn_timeout;
    logic [7:0]         txn_rd_byte;
    logic               restart;
    logic               begin_seq, fail, cnt_wrap;
    logic [1:0]         fail_code;
    logic               wait_done, last_reg, last_adc;

    always_comb begin
        entry = '0;
        for (int k = 0; k < N_REGS; k++)
            if (reg_q == 4'(k))
                entry = cfg_table[16*k +: 16];
    end

    assign wait_done = (cnt_q == 32'(WAIT_PERIOD - 1));
    assign last_reg  = (reg_q == 4'(N_REGS - 1));
    assign last_adc  = (adc_q == SEL_W'(N_ADC - 1));

    always_comb begin
        state_d    = state_q;
        adc_d      = adc_q;
        reg_d      = reg_q;
        retry_d    = retry_q;
        next_rd_d  = next_rd_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        toggle_d   = toggle_q;
        err_code_d = err_code_q;
        err_adc_d  = err_adc_q;
        err_reg_d  = err_reg_q;
        begin_seq  = 1'b0;
        fail       = 1'b0;
        fail_code  = ERR_NONE;
        cnt_wrap   = 1'b0;

        case (state_q)
            S_IDLE:   if (start) begin_seq = 1'b1;
            S_RESET:  if (cnt_q == 32'(RESET_PERIOD - 1)) state_d = S_POST;
            S_POST: begin
                if (wait_done) begin
                    if (spi_ack) begin
                        fail      = 1'b1;
                        fail_code = ERR_ACK_STUCK;
                    end else begin
                        adc_d     = '0;
                        reg_d     = '0;
                        retry_d   = '0;
                        next_rd_d = 1'b0;
                        state_d   = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ, S_RD_REQ: begin
                if (txn_acked)
                    state_d = (state_q == S_WR_REQ) ? S_WR_ACK : S_RD_ACK;
                else if (txn_timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_ACK_TIMEOUT;
                end
            end
            S_WR_ACK: begin
                if (txn_released) begin
                    next_rd_d = 1'b1;
                    state_d   = S_GAP;
                end else if (txn_timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_ACK_TIMEOUT;
                end
            end
            S_GAP:    if (wait_done) state_d = next_rd_q ? S_RD_REQ : S_WR_REQ;
            S_RD_ACK: begin
                if (txn_released) begin
                    next_rd_d = 1'b0;
                    if (txn_rd_byte == entry[7:0]) begin
                        retry_d = '0;
                        state_d = S_GAP;
                        if (!last_reg) begin
                            reg_d = reg_q + 4'd1;
                        end else if (!last_adc) begin
                            reg_d = '0;
                            adc_d = adc_q + 1'b1;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else if (retry_q < 3'(MAX_RETRY)) begin
                        retry_d = retry_q + 3'd1;
                        state_d = S_GAP;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_MISMATCH;
                    end
                end else if (txn_timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_ACK_TIMEOUT;
                end
            end
            S_DONE:   state_d = (TOGGLE_EN != 0) ? S_TOGGLE : S_IDLE;
            S_TOGGLE: begin
                if (start)
                    begin_seq = 1'b1;
                else if (cnt_q == 32'(TOGGLE_PERIOD - 1)) begin
                    toggle_d = ~toggle_q;
                    cnt_wrap = 1'b1;
                end
            end
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (begin_seq) begin
            state_d    = S_RESET;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            error_d    = 1'b0;
            toggle_d   = 1'b0;
            err_code_d = ERR_NONE;
            err_adc_d  = '0;
            err_reg_d  = '0;
            adc_d      = '0;
            reg_d      = '0;
            retry_d    = '0;
            next_rd_d  = 1'b0;
        end

        // Failure info is latched on the way into S_FAIL, while adc/reg still name the culprit.
        if (fail) begin
            state_d    = S_FAIL;
            error_d    = 1'b1;
            busy_d     = 1'b0;
            err_code_d = fail_code;
            err_adc_d  = adc_q;
            err_reg_d  = reg_q;
        end

        cnt_d = '0;
        if (state_d == state_q && !cnt_wrap &&
            (state_q inside {S_RESET, S_POST, S_GAP, S_TOGGLE}))
            cnt_d = cnt_q + 32'd1;
    end

    assign restart = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            adc_q      <= '0;
            reg_q      <= '0;
            retry_q    <= '0;
            next_rd_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            toggle_q   <= 1'b0;
            err_code_q <= ERR_NONE;
            err_adc_q  <= '0;
            err_reg_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adc_q      <= adc_d;
            reg_q      <= reg_d;
            retry_q    <= retry_d;
            next_rd_q  <= next_rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            toggle_q   <= toggle_d;
            err_code_q <= err_code_d;
            err_adc_q  <= err_adc_d;
            err_reg_q  <= err_reg_d;
        end
    end

    adc_cfg_spi_txn #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_txn (
        .clk             (clk),
        .rst             (rst),
        .req_phase       (state_q == S_WR_REQ || state_q == S_RD_REQ),
        .ack_phase       (state_q == S_WR_ACK || state_q == S_RD_ACK),
        .is_read         (state_q == S_RD_REQ || state_q == S_RD_ACK),
        .restart         (restart),
        .addr            (entry[15:8]),
        .data            (entry[7:0]),
        .spi_ack         (spi_ack),
        .adc_spi_rd_data (adc_spi_rd_data),
        .spi_req         (spi_req),
        .spi_wr_data     (adc_spi_wr_data),
        .acked           (txn_acked),
        .released        (txn_released),
        .timeout         (txn_timeout),
        .rd_byte         (txn_rd_byte)
    );

    assign adc_sel   = adc_q;
    assign adc_reset = (state_q == S_RESET);
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign err_adc   = err_adc_q;
    assign err_reg   = err_reg_q;
    assign state     = state_q;
    assign toggle    = toggle_q;

endmodule

// File: tb/tb_adc_cfg_seq.sv
// Self-checking bench for adc_cfg_seq: an SPI slave model with per-entry
// readback corruption, and a transaction-list reference model.
module tb_adc_cfg_seq;

    localparam int NA = 2;
    localparam int NR = 2;
    localparam int RP = 10;
    localparam int AT = 50;
    localparam int MR = 2;
    localparam int TP = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_table = '0;
    logic        spi_ack = 1'b0;
    logic [7:0]  adc_spi_rd_data = '0;
    logic        spi_req;
    logic [23:0] adc_spi_wr_data;
    logic [0:0]  adc_sel;
    logic        adc_reset, busy, done, error, toggle;
    logic [1:0]  err_code;
    logic [0:0]  err_adc;
    logic [3:0]  err_reg;
    logic [3:0]  state;

    adc_cfg_seq #(
        .N_ADC(NA), .N_REGS(NR), .WAIT_PERIOD(10), .RESET_PERIOD(RP),
        .ACK_TIMEOUT(AT), .MAX_RETRY(MR), .TOGGLE_EN(1), .TOGGLE_PERIOD(TP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_table(cfg_table),
        .spi_req(spi_req), .adc_spi_wr_data(adc_spi_wr_data), .adc_sel(adc_sel),
        .spi_ack(spi_ack), .adc_spi_rd_data(adc_spi_rd_data), .adc_reset(adc_reset),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .err_adc(err_adc), .err_reg(err_reg), .state(state), .toggle(toggle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int mode = 0;                 // 0 = normal slave, 1 = ack stuck high, 2 = never ack
    int bad_left [NA][256];
    logic [7:0] bad_val [NA][256];
    logic [7:0] mem [NA][256];
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic exp_err;
    logic [1:0] exp_code;
    int exp_adc, exp_reg;
    int req_hi_cyc = 0, rst_hi_cyc = 0, unstable = 0;
    logic in_txn = 1'b0;
    int lat = 0, lat_tgt = 0;
    logic [31:0] cur = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI slave: echoes written bytes, or returns bad_val for the next bad_left reads.
    initial forever begin
        @(negedge clk);
        if (spi_req)   req_hi_cyc++;
        if (adc_reset) rst_hi_cyc++;
        if (mode == 1) spi_ack = 1'b1;
        else if (mode == 2) spi_ack = 1'b0;
        else if (spi_ack) begin
            if (!spi_req) spi_ack = 1'b0;
        end else if (!spi_req) begin
            in_txn = 1'b0;
        end else begin
            if (!in_txn) begin
                in_txn = 1'b1;
                cur = {7'd0, adc_sel, adc_spi_wr_data};
                obs_q.push_back(cur);
                lat = 0;
                lat_tgt = $urandom_range(0, 3);
            end else if ({7'd0, adc_sel, adc_spi_wr_data} != cur) begin
                unstable++;
            end
            if (lat >= lat_tgt) begin
                if (!cur[23]) mem[cur[24]][cur[15:8]] = cur[7:0];
                else if (bad_left[cur[24]][cur[15:8]] > 0) begin
                    bad_left[cur[24]][cur[15:8]]--;
                    adc_spi_rd_data = bad_val[cur[24]][cur[15:8]];
                end else adc_spi_rd_data = mem[cur[24]][cur[15:8]];
                spi_ack = 1'b1;
                in_txn = 1'b0;
            end else lat++;
        end
    end

    // Expected transaction list: per chip, per entry, write+read pairs until match or retries run out.
    task automatic build_expect();
        int left [NA][256];
        left = bad_left;
        exp_q.delete();
        exp_err = 1'b0; exp_code = 2'd0; exp_adc = 0; exp_reg = 0;
        for (int a = 0; a < NA && !exp_err; a++)
            for (int r = 0; r < NR && !exp_err; r++) begin
                logic [7:0] ad, dt, got;
                ad = cfg_table[16*r+8 +: 8];
                dt = cfg_table[16*r +: 8];
                for (int t = 0; t <= MR; t++) begin
                    exp_q.push_back({7'd0, 1'(a), 2'b01, 6'd0, ad, dt});
                    exp_q.push_back({7'd0, 1'(a), 2'b11, 6'd0, ad, 8'h00});
                    if (left[a][ad] > 0) begin
                        left[a][ad]--;
                        got = bad_val[a][ad];
                    end else got = dt;
                    if (got == dt) break;
                    if (t == MR) begin
                        exp_err = 1'b1; exp_code = 2'd3; exp_adc = a; exp_reg = r;
                    end
                end
            end
    endtask

    task automatic clear_bad();
        foreach (bad_left[a, b]) begin
            bad_left[a][b] = 0;
            bad_val[a][b] = 8'h00;
        end
    endtask

    task automatic run_seq(input string tag, input bit extra_start);
        obs_q.delete();
        req_hi_cyc = 0; rst_hi_cyc = 0; unstable = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (extra_start) begin
            repeat (25) @(negedge clk);
            start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        check({tag, ":busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic check_outcome(input string tag, input bit check_txns);
        check({tag, ":done"}, 64'(done), 64'(!exp_err));
        check({tag, ":error"}, 64'(error), 64'(exp_err));
        if (exp_err) begin
            check({tag, ":err_code"}, 64'(err_code), 64'(exp_code));
            check({tag, ":err_adc"}, 64'(err_adc), 64'(exp_adc));
            check({tag, ":err_reg"}, 64'(err_reg), 64'(exp_reg));
        end
        if (check_txns) begin
            check({tag, ":n_txn"}, 64'(obs_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
                check($sformatf("%s:txn%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
            check({tag, ":frame_stable"}, 64'(unstable), 64'd0);
        end
        check({tag, ":reset_cycles"}, 64'(rst_hi_cyc), 64'(RP));
    endtask

    function automatic int count_writes(input int a, input logic [7:0] ad);
        int n = 0;
        foreach (obs_q[i])
            if (obs_q[i][31:24] == 8'(a) && obs_q[i][23:22] == 2'b01 && obs_q[i][15:8] == ad)
                n++;
        return n;
    endfunction

    function automatic logic [50:0] all_outputs();
        return {spi_req, adc_spi_wr_data, adc_sel, adc_reset, busy, done, error,
                err_code, err_adc, err_reg, state, toggle};
    endfunction

    initial begin
        int edges, last_edge, bad_gap, first_edge;
        logic prev;
        logic [7:0] a0;

        clear_bad();
        repeat (3) @(negedge clk);
        check("reset:outputs", 64'(all_outputs()), 64'd0);
        rst = 1'b0;

        // Nominal table {15:04, 0A:5C} with echoing slave.
        cfg_table = {16'h0A5C, 16'h1504};
        build_expect();
        run_seq("nominal", 1'b1);
        check_outcome("nominal", 1'b1);

        for (int i = 0; i < 100 && state != 4'd9; i++) @(negedge clk);
        check("toggle:state", 64'(state), 64'd9);
        prev = toggle; edges = 0; last_edge = 0; bad_gap = 0; first_edge = -1;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            if (toggle !== prev) begin
                if (edges == 0) first_edge = i;
                else if (i - last_edge != TP) bad_gap++;
                edges++; last_edge = i; prev = toggle;
            end
        end
        check("toggle:first_edge", 64'(first_edge), 64'(TP - 1));
        check("toggle:edges", 64'(edges), 64'd8);
        check("toggle:bad_gaps", 64'(bad_gap), 64'd0);

        rst = 1'b1;
        @(negedge clk);
        check("midtoggle_reset:outputs", 64'(all_outputs()), 64'd0);
        rst = 1'b0;
        build_expect();
        run_seq("rerun", 1'b0);
        check_outcome("rerun", 1'b1);

        // PDN readback wrong twice on adc0 entry 0, then correct.
        clear_bad();
        bad_left[0][8'h15] = 2; bad_val[0][8'h15] = 8'h00;
        build_expect();
        run_seq("retry_ok", 1'b0);
        check_outcome("retry_ok", 1'b1);
        check("retry_ok:pdn_writes", 64'(count_writes(0, 8'h15)), 64'd3);

        // adc1 entry 1 always reads 0xFF.
        clear_bad();
        bad_left[1][8'h0A] = 100; bad_val[1][8'h0A] = 8'hFF;
        build_expect();
        run_seq("mismatch", 1'b0);
        check_outcome("mismatch", 1'b1);
        check("mismatch:writes", 64'(count_writes(1, 8'h0A)), 64'd3);
        clear_bad();

        // spi_ack stuck high through the post-reset wait.
        mode = 1;
        @(negedge clk);
        exp_q.delete(); exp_err = 1'b1; exp_code = 2'd1; exp_adc = 0; exp_reg = 0;
        run_seq("ack_stuck", 1'b0);
        check_outcome("ack_stuck", 1'b0);
        check("ack_stuck:req_cycles", 64'(req_hi_cyc), 64'd0);

        // Slave never acks.
        mode = 2;
        repeat (2) @(negedge clk);
        exp_err = 1'b1; exp_code = 2'd2; exp_adc = 0; exp_reg = 0;
        run_seq("timeout", 1'b0);
        check_outcome("timeout", 1'b0);
        check("timeout:req_cycles", 64'(req_hi_cyc), 64'(AT));
        check("timeout:req_low", 64'(spi_req), 64'd0);
        mode = 0;
        repeat (2) @(negedge clk);

        // Randomized tables and readback corruption.
        for (int it = 0; it < 6; it++) begin
            clear_bad();
            a0 = 8'($urandom);
            cfg_table = {a0 ^ 8'h80, 8'($urandom), a0, 8'($urandom)};
            for (int a = 0; a < NA; a++)
                for (int r = 0; r < NR; r++) begin
                    logic [7:0] ad;
                    ad = cfg_table[16*r+8 +: 8];
                    bad_left[a][ad] = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 3);
                    bad_val[a][ad]  = 8'($urandom);
                end
            build_expect();
            run_seq($sformatf("rand%0d", it), 1'($urandom_range(0, 1)));
            check_outcome($sformatf("rand%0d", it), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_cfg_seq.md
Name: adc_cfg_seq

Overview:
Multi-chip ADC3424 bring-up sequencer. It pulses the shared ADC reset, then writes a parametrised register table to each of N_ADC chips over the shared SPI master. Every write is read back and compared, with bounded retries and ACK timeouts. On success it raises done and optionally toggles a test output; on failure it latches a diagnostic error code identifying the chip and table entry.

Parameters:
N_ADC, 4, number of ADC chips addressed through adc_sel (1..16)
N_REGS, 2, entries in cfg_table (1..16)
WAIT_PERIOD, 10, idle cycles after reset release and between SPI transactions (>=1)
RESET_PERIOD, 10, adc_reset high time in cycles (>=1)
ACK_TIMEOUT, 1000, max cycles waiting for an spi_ack edge (>=2)
MAX_RETRY, 2, rewrite attempts per entry after a readback mismatch (0..7)
TOGGLE_EN, 1, 1 = enter toggle mode after done
TOGGLE_PERIOD, 1000, cycles per toggle half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; begins a sequence when not busy
cfg_table  in  16*N_REGS  entry k at [16k+15:16k] = {addr[7:0], data[7:0]}; sampled live, must be stable while busy
spi_req  out  1  request to SPI master
adc_spi_wr_data  out  24  SPI frame
adc_sel  out  SEL_W  target chip, SEL_W = max(1,clog2(N_ADC))
spi_ack  in  1  SPI master ack; high from completion until spi_req drops
adc_spi_rd_data  in  8  read data, valid while spi_ack high
adc_reset  out  1  reset to all ADCs
busy  out  1  sequence in progress
done  out  1  sticky success flag
error  out  1  sticky failure flag
err_code  out  2  1=ack stuck high, 2=ack timeout, 3=readback mismatch
err_adc  out  SEL_W  chip index at failure
err_reg  out  4  table index at failure
state  out  4  FSM state encoding, for debug
toggle  out  1  test toggle output

Behaviour:
- Reset: all outputs 0; FSM to S_IDLE; counters, retry count and indices cleared. Reset mid-transaction drops spi_req on the next edge; no cleanup SPI frame is issued.
- Frame format: write = {1'b0,1'b1,6'b0,addr,data}; read = {1'b1,1'b1,6'b0,addr,8'h00}. adc_sel and adc_spi_wr_data are stable for the whole time spi_req is high.
- S_IDLE(0): wait for start. Start clears done, error, err_* and toggle, sets busy, goes to S_RESET. Start is ignored while busy.
- S_RESET(1): adc_reset high for exactly RESET_PERIOD cycles, then S_POST.
- S_POST(2): WAIT_PERIOD cycles. Then if spi_ack=1 go to S_FAIL with code 1; else set adc=0, reg=0, retry=0 and go to S_WR_REQ.
- S_WR_REQ(3): spi_req=1 with the write frame. On the first cycle spi_ack=1, drop spi_req next cycle and go to S_WR_ACK.
- S_WR_ACK(4): wait for spi_ack=0, then S_GAP (next action = read).
- S_GAP(5): WAIT_PERIOD cycles, then perform the pending action.
- S_RD_REQ(6): spi_req=1 with the read frame. When spi_ack=1, capture adc_spi_rd_data that same cycle and go to S_RD_ACK.
- S_RD_ACK(7): wait for spi_ack=0, then evaluate the captured byte:
  - match: advance the entry, or wrap reg to 0 and increment adc; retry cleared; go to S_GAP (next action = write).
  - mismatch with retry<MAX_RETRY: retry++, go to S_GAP (next action = write, same entry).
  - mismatch otherwise: S_FAIL with code 3.
- Last entry of last chip matched: go to S_DONE.
- Timeout: a single counter runs in S_WR_REQ, S_WR_ACK, S_RD_REQ and S_RD_ACK and restarts on each state entry. Reaching ACK_TIMEOUT cycles: drop spi_req, go to S_FAIL with code 2.
- S_DONE(8): done=1, busy=0. If TOGGLE_EN, go to S_TOGGLE; else S_IDLE.
- S_TOGGLE(9): toggle inverts every TOGGLE_PERIOD cycles, so the period is 2*TOGGLE_PERIOD. Toggle holds its value between inversions. Start aborts to S_RESET with toggle=0 and done cleared.
- S_FAIL(10): latch err_code, err_adc and err_reg, set error=1, busy=0, go to S_IDLE.
- Unused FSM encodings go to S_IDLE.
- Counters are 32 bits and compare against PARAM-1. No counter wraps within the parameter ranges.

Decomposition:
- Shared package adc_cfg_pkg: state localparams, err_code values, frame builder constants (RW bit, W bit, zero pad), PDN register address 8'h15.
- One natural sub-module, adc_cfg_spi_txn: one write or read transaction with req/ack handshake, timeout and data capture, reporting done/timeout/rd_byte. The top FSM sequences entries, retries and reset.

Test Plan:
- N_ADC=2, N_REGS=2, table {15:04, 0A:5C}, SPI model echoes written data -> 4 writes and 4 reads in order adc0 r0, adc0 r1, adc1 r0, adc1 r1; done=1, error=0; adc_reset high exactly 10 cycles.
- Model returns 0x00 twice, then 0x04, for adc0 entry 0 with MAX_RETRY=2 -> 3 writes to 0x15; success; done=1.
- Model always returns 0xFF at adc1 entry 1 -> error=1, err_code=3, err_adc=1, err_reg=1, after exactly 3 writes to that entry.
- spi_ack held high through S_POST -> err_code=1; no spi_req asserted ever.
- Model never acks; ACK_TIMEOUT=50 -> spi_req high 50 cycles, then low; err_code=2, err_adc=0, err_reg=0.
- Success with TOGGLE_PERIOD=5, then rst mid-toggle, then start -> toggle period 10 cycles; all outputs 0 after reset; second sequence completes identically.
